// File: rtl/axis_pkt_sink.sv
// ---------------------------------------------------------------------------
// axis_pkt_sink
//
// AXI-Stream receiving endpoint. Accepts packets beat by beat, measures each
// one (beat count and valid-byte count from tkeep), checks tkeep legality and
// emits exactly one status record per packet on a valid/ready status port.
// s_tdata is accepted but never stored.
//
// Handshakes (both ports): a transfer happens on a rising aclk edge where
// valid and ready are both 1. A producer holds valid and payload until the
// transfer. ready never depends on the same port's valid.
//
// Backpressure toward the stream producer comes only from a status record
// that has not yet been consumed. The same rule blocks non-last beats too,
// which keeps s_tready a function of registers and stat_ready only.
//
// Optional feature (compile-time macro AXIS_PKT_SINK_THROTTLE_EN):
//   when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every
//   cycle after reset and s_tready is additionally gated by lfsr[0] to stress
//   producer backpressure. When undefined, no LFSR exists and LFSR_SEED is
//   unused.
//
// Parameters:
//   DATA_WIDTH : tdata width in bits (multiple of 8, >= 8)
//   MAX_BEATS  : largest legal packet length in beats; counters saturate here
//   LFSR_SEED  : non-zero throttle LFSR seed (throttle build only)
//
// Ports:
//   aclk          in   clock, rising edge
//   aresetn       in   asynchronous active-low reset
//   s_tvalid      in   beat valid
//   s_tready      out  sink ready
//   s_tdata       in   payload (ignored)
//   s_tkeep       in   byte enables
//   s_tlast       in   final beat of packet
//   stat_valid    out  status record pending
//   stat_ready    in   status consumer ready
//   stat_beats    out  accepted beats of the packet (saturated at MAX_BEATS)
//   stat_bytes    out  sum of popcount(tkeep) over the counted beats
//   stat_err_keep out  tkeep violation seen in the packet
//   stat_err_ovf  out  packet exceeded MAX_BEATS
// ---------------------------------------------------------------------------
module axis_pkt_sink #(
    parameter int          DATA_WIDTH = 64,
    parameter int          MAX_BEATS  = 1024,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    localparam int         KW         = DATA_WIDTH / 8,
    localparam int         BW         = $clog2(MAX_BEATS + 1),
    localparam int         YW         = $clog2(MAX_BEATS * DATA_WIDTH / 8 + 1)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KW-1:0]         s_tkeep,
    input  logic                  s_tlast,
    output logic                  stat_valid,
    input  logic                  stat_ready,
    output logic [BW-1:0]         stat_beats,
    output logic [YW-1:0]         stat_bytes,
    output logic                  stat_err_keep,
    output logic                  stat_err_ovf
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    // live_q holds s_tready low until the first edge after reset release.
    logic          live_q;

    // Running per-packet accumulators.
    logic [BW-1:0] beat_cnt_q,     beat_cnt_d;
    logic [YW-1:0] byte_cnt_q,     byte_cnt_d;
    logic          err_keep_acc_q, err_keep_acc_d;
    logic          ovf_acc_q,      ovf_acc_d;

    // Status record register.
    logic          stat_valid_q,    stat_valid_d;
    logic [BW-1:0] stat_beats_q,    stat_beats_d;
    logic [YW-1:0] stat_bytes_q,    stat_bytes_d;
    logic          stat_err_keep_q, stat_err_keep_d;
    logic          stat_err_ovf_q,  stat_err_ovf_d;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------
    function automatic logic [YW-1:0] popcount(input logic [KW-1:0] v);
        logic [YW-1:0] c;
        c = '0;
        for (int i = 0; i < KW; i++) begin
            c = c + YW'(v[i]);
        end
        return c;
    endfunction

    // The payload is not stored; fold it into a sink so it is not dangling.
    logic unused_tdata;
    assign unused_tdata = ^s_tdata;

    // -----------------------------------------------------------------------
    // Optional throttle LFSR
    // -----------------------------------------------------------------------
    logic throttle_ok;

`ifdef AXIS_PKT_SINK_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Taps 16,14,13,11 in 1-based numbering map to bits 15,13,12,10.
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign throttle_ok = lfsr_q[0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_fb};
        end
    end
`else
    logic [15:0] unused_lfsr_seed;
    assign unused_lfsr_seed = LFSR_SEED;
    assign throttle_ok      = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Stream side
    // -----------------------------------------------------------------------
    // The stream may advance whenever the status slot is empty or is being
    // emptied in this same cycle.
    assign s_tready = live_q & (~stat_valid_q | stat_ready) & throttle_ok;

    logic          xfer;
    logic          last_xfer;
    logic [KW-1:0] keep_inc;
    logic          keep_full;
    logic          keep_contig;
    logic          keep_bad;
    logic          room;
    logic [BW-1:0] pkt_beats;
    logic [YW-1:0] pkt_bytes;
    logic          pkt_err_keep;
    logic          pkt_err_ovf;

    always_comb begin
        xfer      = s_tvalid & s_tready;
        last_xfer = xfer & s_tlast;

        // A contiguous-from-byte-0 mask 2^k-1 has no bit in common with
        // itself plus one; zero is excluded explicitly.
        keep_inc    = s_tkeep + KW'(1);
        keep_full   = &s_tkeep;
        keep_contig = (s_tkeep != '0) && ((s_tkeep & keep_inc) == '0);
        keep_bad    = s_tlast ? ~keep_contig : ~keep_full;

        // Packet totals including the beat currently on the bus. Once the
        // beat limit is reached the counts freeze and the overflow flag
        // sticks, but keep errors are still recorded for every beat.
        room         = beat_cnt_q < BW'(MAX_BEATS);
        pkt_beats    = room ? beat_cnt_q + BW'(1)         : beat_cnt_q;
        pkt_bytes    = room ? byte_cnt_q + popcount(s_tkeep) : byte_cnt_q;
        pkt_err_keep = err_keep_acc_q | keep_bad;
        pkt_err_ovf  = ovf_acc_q | ~room;
    end

    // -----------------------------------------------------------------------
    // Next-state: running counters
    // -----------------------------------------------------------------------
    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        err_keep_acc_d = err_keep_acc_q;
        ovf_acc_d      = ovf_acc_q;

        if (xfer) begin
            if (s_tlast) begin
                // Totals move to the status register; start the next packet.
                beat_cnt_d     = '0;
                byte_cnt_d     = '0;
                err_keep_acc_d = 1'b0;
                ovf_acc_d      = 1'b0;
            end else begin
                beat_cnt_d     = pkt_beats;
                byte_cnt_d     = pkt_bytes;
                err_keep_acc_d = pkt_err_keep;
                ovf_acc_d      = pkt_err_ovf;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: status record
    // -----------------------------------------------------------------------
    always_comb begin
        stat_valid_d    = stat_valid_q;
        stat_beats_d    = stat_beats_q;
        stat_bytes_d    = stat_bytes_q;
        stat_err_keep_d = stat_err_keep_q;
        stat_err_ovf_d  = stat_err_ovf_q;

        if (stat_valid_q && stat_ready) begin
            stat_valid_d = 1'b0;
        end

        // A last transfer in the same cycle as a consume wins: the new record
        // replaces the one being consumed and the slot stays full.
        if (last_xfer) begin
            stat_valid_d    = 1'b1;
            stat_beats_d    = pkt_beats;
            stat_bytes_d    = pkt_bytes;
            stat_err_keep_d = pkt_err_keep;
            stat_err_ovf_d  = pkt_err_ovf;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q          <= 1'b0;
            beat_cnt_q      <= '0;
            byte_cnt_q      <= '0;
            err_keep_acc_q  <= 1'b0;
            ovf_acc_q       <= 1'b0;
            stat_valid_q    <= 1'b0;
            stat_beats_q    <= '0;
            stat_bytes_q    <= '0;
            stat_err_keep_q <= 1'b0;
            stat_err_ovf_q  <= 1'b0;
        end else begin
            live_q          <= 1'b1;
            beat_cnt_q      <= beat_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            err_keep_acc_q  <= err_keep_acc_d;
            ovf_acc_q       <= ovf_acc_d;
            stat_valid_q    <= stat_valid_d;
            stat_beats_q    <= stat_beats_d;
            stat_bytes_q    <= stat_bytes_d;
            stat_err_keep_q <= stat_err_keep_d;
            stat_err_ovf_q  <= stat_err_ovf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign stat_valid    = stat_valid_q;
    assign stat_beats    = stat_beats_q;
    assign stat_bytes    = stat_bytes_q;
    assign stat_err_keep = stat_err_keep_q;
    assign stat_err_ovf  = stat_err_ovf_q;

endmodule

// File: tb/tb_axis_pkt_sink.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_sink
//
// Bench for axis_pkt_sink with DATA_WIDTH=64 and MAX_BEATS=4 (small limit so
// overflow is reachable). A status monitor keeps a reference model built from
// the packet rules (list of keeps per packet -> expected record) and checks
// every consumed record and record stability under backpressure. Directed
// timing tests run in the default build; the throttle test runs when
// AXIS_PKT_SINK_THROTTLE_EN is defined.
// ---------------------------------------------------------------------------
module tb_axis_pkt_sink;

  localparam int DW   = 64;
  localparam int MAXB = 4;
  localparam int KW   = DW / 8;
  localparam int BW   = $clog2(MAXB + 1);
  localparam int YW   = $clog2(MAXB * KW + 1);
  localparam int W    = BW + YW + 2;

  typedef logic [W-1:0] rec_t;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          stat_valid;
  logic          stat_ready;
  logic [BW-1:0] stat_beats;
  logic [YW-1:0] stat_bytes;
  logic          stat_err_keep;
  logic          stat_err_ovf;

  always #5 aclk = ~aclk;

  axis_pkt_sink #(
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .stat_valid    (stat_valid),
    .stat_ready    (stat_ready),
    .stat_beats    (stat_beats),
    .stat_bytes    (stat_bytes),
    .stat_err_keep (stat_err_keep),
    .stat_err_ovf  (stat_err_ovf)
  );

  // ---------------- bookkeeping ----------------
  int n_checks  = 0;
  int n_err     = 0;
  int stall_cnt = 0;
  int rec_count = 0;
  bit rand_sr_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [KW-1:0] cur_keeps[$];
  logic [W-1:0]  exp_q[$];

  function automatic bit legal_last(input logic [KW-1:0] kp);
    bit ok;
    ok = 1'b0;
    for (int k = 1; k <= KW; k++) begin
      if (kp == (8'hFF >> (KW - k))) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic rec_t model_pkt();
    int   n;
    int   cnt;
    int   bytes;
    logic ek;
    n     = cur_keeps.size();
    cnt   = (n < MAXB) ? n : MAXB;
    bytes = 0;
    ek    = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i < cnt) bytes += $countones(cur_keeps[i]);
      if (i < n - 1) begin
        if (cur_keeps[i] != 8'hFF) ek = 1'b1;
      end else if (!legal_last(cur_keeps[i])) begin
        ek = 1'b1;
      end
    end
    return {BW'(cnt), YW'(bytes), ek, (n > MAXB)};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  // Samples mid-low-phase, after all drivers have settled, and treats the
  // snapshot as what the next rising edge will act on.
  initial begin : monitor
    bit   prev_hold;
    rec_t prev_rec;
    rec_t cur_rec;
    rec_t e;
    prev_hold = 1'b0;
    prev_rec  = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        cur_keeps.delete();
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        cur_rec = {stat_beats, stat_bytes, stat_err_keep, stat_err_ovf};
        if (prev_hold) begin
          chk("stat_hold_valid", stat_valid, 1);
          chk("stat_hold_record", cur_rec, prev_rec);
        end
        prev_hold = stat_valid && !stat_ready;
        prev_rec  = cur_rec;
        if (stat_valid && stat_ready) begin
          rec_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_record", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("record", cur_rec, e);
          end
        end
        if (s_tvalid && s_tready) begin
          cur_keeps.push_back(s_tkeep);
          if (s_tlast) begin
            exp_q.push_back(model_pkt());
            cur_keeps.delete();
          end
        end
      end
    end
  end

  // Random status-consumer backpressure.
  initial begin : sr_gen
    forever begin
      @(negedge aclk);
      if (rand_sr_en) stat_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [KW-1:0] k, input logic l);
    int waited;
    waited = 0;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tkeep  = k;
    s_tlast  = l;
    s_tdata  = {$urandom, $urandom};
    #1;
    while (s_tready !== 1'b1 && waited < 200) begin
      @(negedge aclk);
      #1;
      waited++;
      stall_cnt++;
    end
    if (s_tready !== 1'b1) chk("send_timeout_tready", s_tready, 1);
    @(posedge aclk);
  endtask

  task automatic go_idle();
    @(negedge aclk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int              n;
    logic [5:0][7:0] k;
    int              eb;
    int              ey;
    logic            eek;
    logic            eeo;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [47:0] ks, input int eb,
                              input int ey, input logic eek, input logic eeo);
    vec_t v;
    v.n = n; v.k = ks; v.eb = eb; v.ey = ey; v.eek = eek; v.eeo = eeo;
    return v;
  endfunction

  vec_t tbl[12];

  // ---------------- main sequence ----------------
  initial begin : main
    int base;
    logic [KW-1:0] k;

    tbl[0]  = mk(3, {8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hFF}, 3, 20, 1'b0, 1'b0);
    tbl[1]  = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h7F}, 2, 15, 1'b1, 1'b0);
    tbl[2]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1,  0, 1'b1, 1'b0);
    tbl[3]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0E}, 1,  3, 1'b1, 1'b0);
    tbl[4]  = mk(6, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4, 32, 1'b0, 1'b1);
    tbl[5]  = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 1,  8, 1'b0, 1'b0);
    tbl[6]  = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF}, 2,  9, 1'b0, 1'b0);
    tbl[7]  = mk(4, {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4, 32, 1'b0, 1'b0);
    tbl[8]  = mk(5, {8'h00, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4, 32, 1'b0, 1'b1);
    tbl[9]  = mk(5, {8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4, 32, 1'b1, 1'b1);
    tbl[10] = mk(1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}, 1,  6, 1'b0, 1'b0);
    tbl[11] = mk(2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'hFF}, 2,  9, 1'b1, 1'b0);

    aresetn    = 1'b1;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = 1'b0;
    stat_ready = 1'b1;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_tready", s_tready, 0);
    chk("rst_stat_valid", stat_valid, 0);
    chk("rst_beats", stat_beats, 0);
    chk("rst_bytes", stat_bytes, 0);
    chk("rst_err_keep", stat_err_keep, 0);
    chk("rst_err_ovf", stat_err_ovf, 0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("tready_at_release", s_tready, 0);
`ifndef AXIS_PKT_SINK_THROTTLE_EN
    @(negedge aclk);
    #1;
    chk("tready_one_edge_after_release", s_tready, 1);
`endif

    // ---- table-driven packets, stat_ready held 1 ----
    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < tbl[i].n; b++) send_beat(tbl[i].k[b], b == tbl[i].n - 1);
      go_idle();
      #1;
      chk($sformatf("tbl%0d_latency_valid", i), stat_valid, 1);
      chk($sformatf("tbl%0d_beats", i), stat_beats, tbl[i].eb);
      chk($sformatf("tbl%0d_bytes", i), stat_bytes, tbl[i].ey);
      chk($sformatf("tbl%0d_err_keep", i), stat_err_keep, tbl[i].eek);
      chk($sformatf("tbl%0d_err_ovf", i), stat_err_ovf, tbl[i].eeo);
    end

`ifndef AXIS_PKT_SINK_THROTTLE_EN
    // ---- back-to-back packets: no stall cycles at all ----
    stall_cnt = 0;
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'h0F, 1'b1);
    send_beat(8'hFF, 1'b0);
    send_beat(8'h01, 1'b1);
    send_beat(8'hFF, 1'b1);
    go_idle();
    chk("back_to_back_stalls", stall_cnt, 0);
    repeat (2) @(negedge aclk);

    // ---- backpressure: A (1 beat) then B (2 beats) with stat_ready=0 ----
    stat_ready = 1'b0;
    send_beat(8'hFF, 1'b1);
    @(negedge aclk);
    s_tvalid = 1'b1; s_tkeep = 8'hFF; s_tlast = 1'b0;
    #1;
    chk("bp_tready_drops", s_tready, 0);
    chk("bp_a_valid", stat_valid, 1);
    chk("bp_a_beats", stat_beats, 1);
    chk("bp_a_bytes", stat_bytes, 8);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      #1;
      chk("bp_hold_tready", s_tready, 0);
      chk("bp_hold_valid", stat_valid, 1);
      chk("bp_hold_beats", stat_beats, 1);
    end
    @(negedge aclk);
    stat_ready = 1'b1;
    #1;
    chk("bp_release_tready", s_tready, 1);
    @(negedge aclk);
    stat_ready = 1'b0;
    s_tlast = 1'b1;
    #1;
    chk("bp_a_consumed", stat_valid, 0);
    chk("bp_b2_tready", s_tready, 1);
    @(negedge aclk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    chk("bp_b_valid", stat_valid, 1);
    chk("bp_b_beats", stat_beats, 2);
    chk("bp_b_bytes", stat_bytes, 16);
    stat_ready = 1'b1;
    @(negedge aclk);
    #1;
    chk("bp_b_consumed", stat_valid, 0);

    // ---- reset mid-packet ----
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b0);
    @(negedge aclk);
    s_tvalid = 1'b0;
    aresetn  = 1'b0;
    #1;
    chk("midrst_tready", s_tready, 0);
    chk("midrst_valid", stat_valid, 0);
    chk("midrst_beats", stat_beats, 0);
    chk("midrst_bytes", stat_bytes, 0);
    chk("midrst_errs", {stat_err_keep, stat_err_ovf}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("midrst_tready_release", s_tready, 0);
    @(negedge aclk);
    #1;
    chk("midrst_tready_live", s_tready, 1);
    send_beat(8'hFF, 1'b1);
    go_idle();
    #1;
    chk("midrst_fresh_valid", stat_valid, 1);
    chk("midrst_fresh_beats", stat_beats, 1);
    chk("midrst_fresh_bytes", stat_bytes, 8);
`endif

    // ---- randomized packets with random status backpressure ----
    rand_sr_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        if (b == n - 1) begin
          if ($urandom_range(0, 2) != 0) k = 8'hFF >> $urandom_range(0, 7);
          else k = 8'($urandom);
        end else begin
          if ($urandom_range(0, 3) == 0) k = 8'($urandom);
          else k = 8'hFF;
        end
        send_beat(k, b == n - 1);
      end
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    #1;
    rand_sr_en = 1'b0;
    stat_ready = 1'b1;
    repeat (4) @(negedge aclk);

`ifdef AXIS_PKT_SINK_THROTTLE_EN
    // ---- throttle: 100 single-beat packets ----
    stall_cnt = 0;
    base = rec_count;
    for (int p = 0; p < 100; p++) send_beat(8'hFF >> $urandom_range(0, 7), 1'b1);
    go_idle();
    repeat (4) @(negedge aclk);
    chk("throttle_records", rec_count - base, 100);
    chk("throttle_saw_tready_low", stall_cnt > 0, 1);
`else
    base = rec_count;
`endif

    chk("scoreboard_drained", exp_q.size(), 0);
    chk("no_partial_packet", cur_keeps.size(), 0);
    chk("records_seen", rec_count > 60, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
